// File: rtl/vga_display_driver_if.sv
// Display-side bundle between the VGA timing core, the block controller and the board pins.
// VGA_TEST_PATTERN_EN adds the test_mode select for the built-in colour bars.
interface vga_display_driver_if;
  logic [11:0] rgb;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic        bright;
  logic        hSync;
  logic        vSync;
  logic [3:0]  vgaR;
  logic [3:0]  vgaG;
  logic [3:0]  vgaB;
  logic        frame_tick;
`ifdef VGA_TEST_PATTERN_EN
  logic        test_mode;
`endif

  modport master (
`ifdef VGA_TEST_PATTERN_EN
    input  test_mode,
`endif
    input  rgb,
    output hCount, vCount, bright, hSync, vSync, vgaR, vgaG, vgaB, frame_tick
  );

  modport slave (
`ifdef VGA_TEST_PATTERN_EN
    output test_mode,
`endif
    output rgb,
    input  hCount, vCount, bright, hSync, vSync, vgaR, vgaG, vgaB, frame_tick
  );
endinterface

// File: rtl/vga_display_driver.sv
// 640x480@60 VGA timing generator with a one-pixel registered sync/colour stage and frame tick.
// Optional VGA_TEST_PATTERN_EN replaces rgb with eight colour bars while test_mode is high.
module vga_display_driver #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_ACT_START = 144,
  parameter int unsigned H_ACT_END   = 784,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_ACT_START = 35,
  parameter int unsigned V_ACT_END   = 515
) (
  input logic                  clk,
  input logic                  rst,
  vga_display_driver_if.master vga
);

  localparam int unsigned     DivW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast   = DivW'(CLK_DIV - 1);
  localparam logic [9:0]      HLast     = 10'(H_TOTAL - 1);
  localparam logic [9:0]      VLast     = 10'(V_TOTAL - 1);
  localparam logic [9:0]      HSyncEnd  = 10'(H_SYNC);
  localparam logic [9:0]      VSyncEnd  = 10'(V_SYNC);
  localparam logic [9:0]      HActStart = 10'(H_ACT_START);
  localparam logic [9:0]      HActEnd   = 10'(H_ACT_END);
  localparam logic [9:0]      VActStart = 10'(V_ACT_START);
  localparam logic [9:0]      VActEnd   = 10'(V_ACT_END);

  logic [DivW-1:0] div_q, div_d;
  logic [9:0]      h_q, h_d, v_q, v_d;
  logic            hsync_q, vsync_q;
  logic [11:0]     pix_q;
  logic            tick_q, tick_d;
  logic            pix_en, h_end, v_end, bright;
  logic [11:0]     src;

  always_comb begin
    pix_en = (div_q == DivLast);
    div_d  = pix_en ? '0 : div_q + DivW'(1);
    h_end  = (h_q == HLast);
    v_end  = (v_q == VLast);
    h_d    = h_q;
    v_d    = v_q;
    if (pix_en) begin
      if (h_end) begin
        h_d = '0;
        v_d = v_end ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
    // Pulse lands on the same edge that moves the counters to (0,0).
    tick_d = pix_en & h_end & v_end;
    bright = (h_q >= HActStart) && (h_q < HActEnd) && (v_q >= VActStart) && (v_q < VActEnd);
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [9:0] BarWidth = 10'((H_ACT_END - H_ACT_START) / 8);

  logic [9:0]  bar_idx;
  logic [11:0] bar_colour;

  always_comb begin
    bar_idx = (h_q - HActStart) / BarWidth;
    case (bar_idx)
      10'd0:   bar_colour = 12'hFFF;
      10'd1:   bar_colour = 12'hFF0;
      10'd2:   bar_colour = 12'h0FF;
      10'd3:   bar_colour = 12'h0F0;
      10'd4:   bar_colour = 12'hF0F;
      10'd5:   bar_colour = 12'hF00;
      10'd6:   bar_colour = 12'h00F;
      default: bar_colour = 12'h000;
    endcase
    src = vga.test_mode ? bar_colour : vga.rgb;
  end
`else
  assign src = vga.rgb;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      pix_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      h_q    <= h_d;
      v_q    <= v_d;
      tick_q <= tick_d;
      // Sync and colour come from the pre-increment counts so pins stay one pixel behind.
      if (pix_en) begin
        hsync_q <= ~(h_q < HSyncEnd);
        vsync_q <= ~(v_q < VSyncEnd);
        pix_q   <= bright ? src : 12'h000;
      end
    end
  end

  assign vga.hCount     = h_q;
  assign vga.vCount     = v_q;
  assign vga.bright     = bright;
  assign vga.hSync      = hsync_q;
  assign vga.vSync      = vsync_q;
  assign vga.vgaR       = pix_q[11:8];
  assign vga.vgaG       = pix_q[7:4];
  assign vga.vgaB       = pix_q[3:0];
  assign vga.frame_tick = tick_q;

endmodule

// File: tb/tb_vga_display_driver.sv
// Scoreboard bench for vga_display_driver on a shrunken raster (24x10 pixels, 16x5 visible).
// Sample index k counts clk edges since reset release; pixel p = k/4, so hCount = p%24.
module tb_vga_display_driver;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned H_TOTAL = 24;
  localparam int unsigned H_SYNC = 3;
  localparam int unsigned H_ACT_START = 5;
  localparam int unsigned H_ACT_END = 21;
  localparam int unsigned V_TOTAL = 10;
  localparam int unsigned V_SYNC = 2;
  localparam int unsigned V_ACT_START = 3;
  localparam int unsigned V_ACT_END = 8;

  typedef struct {
    bit          in_rst;
    int          cyc;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic [11:0] pins;
    logic        br;
    logic        tk;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  vga_display_driver_if vga ();

  vga_display_driver #(
    .CLK_DIV    (CLK_DIV),
    .H_TOTAL    (H_TOTAL),
    .H_SYNC     (H_SYNC),
    .H_ACT_START(H_ACT_START),
    .H_ACT_END  (H_ACT_END),
    .V_TOTAL    (V_TOTAL),
    .V_SYNC     (V_SYNC),
    .V_ACT_START(V_ACT_START),
    .V_ACT_END  (V_ACT_END)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga(vga)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at k=%0d: got %0h, expected %0h", name, k, act, exp);
    end
  endtask

  task automatic push(input bit in_rst, input int k, input int h, input int v, input bit hs,
                      input bit vs, input logic [11:0] pins, input bit br, input bit tk);
    exp_t e;
    e.in_rst = in_rst;
    e.cyc    = k;
    e.h      = 10'(h);
    e.v      = 10'(v);
    e.hs     = hs;
    e.vs     = vs;
    e.pins   = pins;
    e.br     = br;
    e.tk     = tk;
    sb_q.push_back(e);
  endtask

  // Monitor: pops the head entry on the sample it names and compares every output.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q[0];
      if ((e.in_rst == !rst) && (e.in_rst || e.cyc <= cyc)) begin
        void'(sb_q.pop_front());
        if (!e.in_rst && e.cyc != cyc) begin
          chk("sample_missed", e.cyc, 32'(cyc), 32'(e.cyc));
        end else begin
          chk("hCount", cyc, 32'(vga.hCount), 32'(e.h));
          chk("vCount", cyc, 32'(vga.vCount), 32'(e.v));
          chk("hSync", cyc, 32'(vga.hSync), 32'(e.hs));
          chk("vSync", cyc, 32'(vga.vSync), 32'(e.vs));
          chk("pins", cyc, 32'({vga.vgaR, vga.vgaG, vga.vgaB}), 32'(e.pins));
          chk("bright", cyc, 32'(vga.bright), 32'(e.br));
          chk("frame_tick", cyc, 32'(vga.frame_tick), 32'(e.tk));
        end
      end
    end
  end

  initial begin
    int hs_low;
    int vs_low;
    int ticks;
    logic [11:0] c0, c1, c6, c7;
    n_checks = 0;
    n_fail   = 0;
    hs_low   = 0;
    vs_low   = 0;
    ticks    = 0;
    rst      = 1'b0;
    vga.rgb  = 12'hABC;
`ifdef VGA_TEST_PATTERN_EN
    vga.test_mode = 1'b0;
`endif

    // Segment 1: rgb=ABC, first frame plus a bit.
    push(1, 0, 0, 0, 1, 1, 12'h000, 0, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    push(0,    3,  0, 0, 1, 1, 12'h000, 0, 0);
    push(0,    4,  1, 0, 0, 0, 12'h000, 0, 0);
    push(0,   12,  3, 0, 0, 0, 12'h000, 0, 0);
    push(0,   16,  4, 0, 1, 0, 12'h000, 0, 0);
    push(0,   96,  0, 1, 1, 0, 12'h000, 0, 0);
    push(0,  192,  0, 2, 1, 0, 12'h000, 0, 0);
    push(0,  196,  1, 2, 0, 1, 12'h000, 0, 0);
    push(0,  308,  5, 3, 1, 1, 12'h000, 1, 0);
    push(0,  312,  6, 3, 1, 1, 12'hABC, 1, 0);
    push(0,  372, 21, 3, 1, 1, 12'hABC, 0, 0);
    push(0,  376, 22, 3, 1, 1, 12'h000, 0, 0);
    push(0,  756, 21, 7, 1, 1, 12'hABC, 0, 0);
    push(0,  788,  5, 8, 1, 1, 12'h000, 0, 0);
    push(0,  792,  6, 8, 1, 1, 12'h000, 0, 0);
    push(0,  959, 23, 9, 1, 1, 12'h000, 0, 0);
    push(0,  960,  0, 0, 1, 1, 12'h000, 0, 1);
    push(0,  961,  0, 0, 1, 1, 12'h000, 0, 0);
    push(0, 1384, 10, 4, 1, 1, 12'hABC, 1, 0);

    for (int k = 1; k <= 960; k++) begin
      @(negedge clk);
      if (!vga.hSync) hs_low++;
      if (!vga.vSync) vs_low++;
      if (vga.frame_tick) ticks++;
    end
    chk("hsync_low_clks_per_frame", 960, 32'(hs_low), 32'd120);
    chk("vsync_low_clks_per_frame", 960, 32'(vs_low), 32'd192);
    chk("frame_ticks_per_frame", 960, 32'(ticks), 32'd1);

    // Segment 2: reset at (10,4), then a fresh frame with new colour source.
    repeat (1384 - 960) @(negedge clk);
    push(1, 0, 0, 0, 1, 1, 12'h000, 0, 0);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
`ifdef VGA_TEST_PATTERN_EN
    vga.test_mode = 1'b1;
    c0 = 12'hFFF;
    c1 = 12'hFF0;
    c6 = 12'h00F;
    c7 = 12'h000;
`else
    c0 = 12'h5A3;
    c1 = 12'h5A3;
    c6 = 12'h5A3;
    c7 = 12'h5A3;
`endif
    vga.rgb = 12'h5A3;
    push(0,   4,  1, 0, 0, 0, 12'h000, 0, 0);
    push(0, 504,  6, 5, 1, 1, c0, 1, 0);
    push(0, 512,  8, 5, 1, 1, c1, 1, 0);
    push(0, 552, 18, 5, 1, 1, c6, 1, 0);
    push(0, 560, 20, 5, 1, 1, c7, 1, 0);
    push(0, 959, 23, 9, 1, 1, 12'h000, 0, 0);
    push(0, 960,  0, 0, 1, 1, 12'h000, 0, 1);
    #2 rst = 1'b1;

    ticks = 0;
    for (int k = 1; k <= 959; k++) begin
      @(negedge clk);
      if (vga.frame_tick) ticks++;
    end
    chk("no_tick_after_truncated_frame", 959, 32'(ticks), 32'd0);
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", cyc, 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
